// File: rtl/phase_sequencer.sv
// Five-phase (F,R,X,M,W) one-hot sequencer with memory-wait watchdog and retire counter.
// Optional build macro PHASE_SKIP_M_EN: X goes straight to W when mem_op=0.
module phase_sequencer #(
    parameter int unsigned WAIT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        mem_op,
    input  logic        halt,
    input  logic        resume,
    output logic [4:0]  phase,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        halted,
    output logic        bus_err,
    output logic [31:0] retire_cnt
);

    typedef enum logic [4:0] {
        S_HALT = 5'b00000,
        S_F    = 5'b00001,
        S_R    = 5'b00010,
        S_X    = 5'b00100,
        S_M    = 5'b01000,
        S_W    = 5'b10000
    } state_t;

    state_t              state, state_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;
    logic                err_next;
    logic                waiting;

    always_comb begin
        state_next = state;
        err_next   = bus_err;
        waiting    = 1'b0;
        case (state)
            S_F: begin
                if (imem_ack) begin
                    state_next = S_R;
                end else if (wait_cnt == '1) begin
                    state_next = S_HALT;
                    err_next   = 1'b1;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_R: state_next = S_X;
            S_X: begin
`ifdef PHASE_SKIP_M_EN
                state_next = mem_op ? S_M : S_W;
`else
                state_next = S_M;
`endif
            end
            S_M: begin
                if (!mem_op || dmem_ack) begin
                    state_next = S_W;
                end else if (wait_cnt == '1) begin
                    state_next = S_HALT;
                    err_next   = 1'b1;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_W: state_next = halt ? S_HALT : S_F;
            S_HALT: begin
                if (resume && !bus_err) begin
                    state_next = S_F;
                end
            end
            default: state_next = S_F;
        endcase

        // Any state change restarts the wait count; an ack on the limit cycle wins above.
        wait_next = wait_cnt;
        if (state_next != state) begin
            wait_next = '0;
        end else if (waiting) begin
            wait_next = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_F;
            wait_cnt   <= '0;
            bus_err    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            bus_err  <= err_next;
            if (state == S_W) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    assign phase    = state;
    assign imem_req = state[0];
    assign dmem_req = state[3] & mem_op;
    assign halted   = (state == S_HALT);

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed self-checking bench for phase_sequencer (WAIT_W=3 so the watchdog fires quickly).
// Honours PHASE_SKIP_M_EN when the design is built with it.
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst, imem_ack, dmem_ack, mem_op, halt, resume;
    logic [4:0]  phase;
    logic        imem_req, dmem_req, halted, bus_err;
    logic [31:0] retire_cnt;

    int checks = 0;
    int fails  = 0;

    phase_sequencer #(.WAIT_W(3)) dut (
        .clk(clk), .rst(rst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .mem_op(mem_op), .halt(halt), .resume(resume), .phase(phase),
        .imem_req(imem_req), .dmem_req(dmem_req), .halted(halted),
        .bus_err(bus_err), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        imem_ack = 0; dmem_ack = 0; mem_op = 0; halt = 0; resume = 0;
        do_reset();
        checks++; if (phase !== 5'h01) begin fails++; $display("FAIL reset_phase: got %h expected 01", phase); end
        checks++; if (imem_req !== 1'b1) begin fails++; $display("FAIL reset_imem_req: got %b expected 1", imem_req); end
        checks++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL reset_dmem_req: got %b expected 0", dmem_req); end
        checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (bus_err !== 1'b0) begin fails++; $display("FAIL reset_bus_err: got %b expected 0", bus_err); end
        checks++; if (retire_cnt !== 32'd0) begin fails++; $display("FAIL reset_retire: got %0d expected 0", retire_cnt); end
        checks++; if (dut.wait_cnt !== 3'd0) begin fails++; $display("FAIL reset_wait_cnt: got %0d expected 0", dut.wait_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_seq [6];
        exp_seq = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h01};
        imem_ack = 1; dmem_ack = 1; mem_op = 1; halt = 0; resume = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            checks++;
            if (phase !== exp_seq[i]) begin
                fails++; $display("FAIL b2b_phase[%0d]: got %h expected %h", i, phase, exp_seq[i]);
            end
        end
        checks++; if (retire_cnt !== 32'd1) begin fails++; $display("FAIL b2b_retire_1: got %0d expected 1", retire_cnt); end
        for (int i = 0; i < 15; i++) tick();
        checks++; if (retire_cnt !== 32'd4) begin fails++; $display("FAIL b2b_retire_4: got %0d expected 4", retire_cnt); end
        checks++; if (phase !== 5'h01) begin fails++; $display("FAIL b2b_phase_20: got %h expected 01", phase); end
    endtask

    task automatic test_fetch_wait();
        imem_ack = 0; dmem_ack = 1; mem_op = 1; halt = 0; resume = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            imem_ack = (i == 3);
            checks++;
            if (phase !== 5'h01 || imem_req !== 1'b1) begin
                fails++; $display("FAIL fetch_hold[%0d]: got phase %h req %b expected 01 1", i, phase, imem_req);
            end
            checks++;
            if (dut.wait_cnt !== 3'(i)) begin
                fails++; $display("FAIL fetch_wait_cnt[%0d]: got %0d expected %0d", i, dut.wait_cnt, i);
            end
            tick();
        end
        imem_ack = 0;
        checks++; if (phase !== 5'h02) begin fails++; $display("FAIL fetch_to_r: got %h expected 02", phase); end
        checks++; if (imem_req !== 1'b0) begin fails++; $display("FAIL fetch_r_req: got %b expected 0", imem_req); end
        checks++; if (dut.wait_cnt !== 3'd0) begin fails++; $display("FAIL fetch_r_wait_cnt: got %0d expected 0", dut.wait_cnt); end
    endtask

    task automatic test_mem_wait();
        imem_ack = 1; dmem_ack = 0; mem_op = 1; halt = 0; resume = 0;
        do_reset();
        tick(); tick(); tick();
        for (int i = 0; i < 6; i++) begin
            dmem_ack = (i == 5);
            checks++;
            if (phase !== 5'h08 || dmem_req !== 1'b1) begin
                fails++; $display("FAIL mem_hold[%0d]: got phase %h req %b expected 08 1", i, phase, dmem_req);
            end
            tick();
        end
        dmem_ack = 0;
        checks++; if (phase !== 5'h10) begin fails++; $display("FAIL mem_to_w: got %h expected 10", phase); end
        mem_op = 0;
        tick(); tick(); tick();
        checks++; if (phase !== 5'h04) begin fails++; $display("FAIL nomem_x: got %h expected 04", phase); end
        tick();
`ifdef PHASE_SKIP_M_EN
        checks++; if (phase !== 5'h10) begin fails++; $display("FAIL nomem_skip_w: got %h expected 10", phase); end
`else
        checks++; if (phase !== 5'h08 || dmem_req !== 1'b0) begin fails++; $display("FAIL nomem_m: got phase %h req %b expected 08 0", phase, dmem_req); end
        tick();
        checks++; if (phase !== 5'h10) begin fails++; $display("FAIL nomem_w: got %h expected 10", phase); end
`endif
        tick();
        checks++; if (retire_cnt !== 32'd2) begin fails++; $display("FAIL mem_retire: got %0d expected 2", retire_cnt); end
    endtask

    task automatic test_halt();
        int n;
        imem_ack = 1; dmem_ack = 1; mem_op = 0; halt = 1; resume = 1;
        do_reset();
        n = 0;
        while (phase !== 5'h10 && n < 10) begin
            tick(); n++;
        end
        checks++; if (phase !== 5'h10) begin fails++; $display("FAIL halt_reach_w: got %h expected 10", phase); end
        tick();
        halt = 0; resume = 0;
        checks++; if (phase !== 5'h00 || halted !== 1'b1 || imem_req !== 1'b0) begin
            fails++; $display("FAIL halt_state: got phase %h halted %b req %b expected 00 1 0", phase, halted, imem_req);
        end
        checks++; if (retire_cnt !== 32'd1) begin fails++; $display("FAIL halt_retire: got %0d expected 1", retire_cnt); end
        tick();
        checks++; if (phase !== 5'h00) begin fails++; $display("FAIL halt_stays: got %h expected 00", phase); end
        resume = 1;
        tick();
        resume = 0;
        checks++; if (phase !== 5'h01 || halted !== 1'b0) begin
            fails++; $display("FAIL resume: got phase %h halted %b expected 01 0", phase, halted);
        end
    endtask

    task automatic test_watchdog();
        imem_ack = 0; dmem_ack = 0; mem_op = 1; halt = 0; resume = 0;
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        checks++; if (phase !== 5'h01 || bus_err !== 1'b0) begin
            fails++; $display("FAIL wd_pre: got phase %h err %b expected 01 0", phase, bus_err);
        end
        tick();
        checks++; if (phase !== 5'h00 || halted !== 1'b1 || bus_err !== 1'b1) begin
            fails++; $display("FAIL wd_fire: got phase %h halted %b err %b expected 00 1 1", phase, halted, bus_err);
        end
        resume = 1;
        tick();
        resume = 0;
        checks++; if (phase !== 5'h00 || bus_err !== 1'b1) begin
            fails++; $display("FAIL wd_resume_ignored: got phase %h err %b expected 00 1", phase, bus_err);
        end
        do_reset();
        checks++; if (phase !== 5'h01 || bus_err !== 1'b0) begin
            fails++; $display("FAIL wd_reset: got phase %h err %b expected 01 0", phase, bus_err);
        end
        for (int i = 0; i < 7; i++) tick();
        imem_ack = 1;
        tick();
        imem_ack = 0;
        checks++; if (phase !== 5'h02 || bus_err !== 1'b0) begin
            fails++; $display("FAIL wd_ack_wins: got phase %h err %b expected 02 0", phase, bus_err);
        end
        imem_ack = 1;
        do_reset();
        tick(); tick(); tick();
        for (int i = 0; i < 8; i++) tick();
        checks++; if (phase !== 5'h00 || bus_err !== 1'b1 || retire_cnt !== 32'd0) begin
            fails++; $display("FAIL wd_mem: got phase %h err %b retire %0d expected 00 1 0", phase, bus_err, retire_cnt);
        end
    endtask

    initial begin
        rst = 1; imem_ack = 0; dmem_ack = 0; mem_op = 0; halt = 0; resume = 0;
        test_reset();
        test_back_to_back();
        test_fetch_wait();
        test_mem_wait();
        test_halt();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Generates the one-hot five-phase signal (F, R, X, M, W) that drives the multi-cycle processor core, including the program counter, register file and memory stages. Holds F and M while instruction or data memory has not acknowledged, halts on a decoded halt instruction, and counts retired instructions. A watchdog halts the core with an error flag if memory never responds.

## Interface
- WAIT_W, 8, width of the memory-wait watchdog counter; timeout at 2^WAIT_W-1 wait cycles
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- imem_ack  in  1  instruction memory data valid this cycle
- dmem_ack  in  1  data memory access complete this cycle
- mem_op  in  1  current instruction accesses data memory; stable from R through W
- halt  in  1  current instruction is a halt; sampled in W
- resume  in  1  leave HALT state
- phase  out  5  one-hot phase, bit0=F, bit1=R, bit2=X, bit3=M, bit4=W; all-zero in HALT
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- halted  out  1  sequencer is in HALT
- bus_err  out  1  sticky watchdog timeout flag
- retire_cnt  out  32  count of completed W phases

## Operation
- States: F, R, X, M, W, HALT. phase is the registered one-hot state encoding. HALT encodes as 5'b00000.
- F: hold until imem_ack=1 is sampled, then go to R.
- R to X: unconditional, one cycle.
- X to M: unconditional. The exception is under PHASE_SKIP_M_EN; see Configuration.
- M with mem_op=1: hold until dmem_ack=1, then go to W.
- M with mem_op=0: one cycle, then go to W.
- W: one cycle. retire_cnt increments by 1 on the edge that leaves W.
  - halt=1: go to HALT.
  - halt=0: go to F.
- HALT: resume=1 with bus_err=0 goes to F. resume is ignored while bus_err=1.
- imem_req = phase[F]. dmem_req = phase[M] & mem_op. Both are combinational from state.
- Watchdog wait_cnt (WAIT_W bits):
  - Increments each cycle spent in F without imem_ack.
  - Increments each cycle spent in M with mem_op=1 and no dmem_ack.
  - Clears on any state change.
  - When wait_cnt = 2^WAIT_W-1 and no ack is present: set bus_err and go to HALT next cycle. The ack does not count.
- Only rst clears bus_err.
- retire_cnt wraps from 32'hFFFFFFFF to 0.

## Timing
- Reset values:
  - phase=5'b00001 (F), so imem_req=1 in the first cycle after reset.
  - dmem_req=0, halted=0, bus_err=0, retire_cnt=0, wait_cnt=0.
- rst has priority over every event, including mid-wait, in HALT, and with bus_err set.
- Minimum instruction time:
  - 5 cycles with imem_ack present in the first F cycle and dmem_ack present in the first M cycle.
  - 4 cycles under PHASE_SKIP_M_EN when mem_op=0.
- An ack arriving in the same cycle the watchdog reaches its limit wins: normal transition, no bus_err.
- An ack outside F or M is ignored and does not carry over.
- The downstream PC advances on the edge that ends W. phase[W] is high for exactly one cycle per retired instruction.
- halted = (state==HALT), registered. It rises the cycle after the W edge that sampled halt=1.
- resume and halt are both sampled only in their own states. A resume held during W has no effect.

## Configuration
- PHASE_SKIP_M_EN
  - Defined: in X, mem_op=0 goes directly to W and M is never entered for that instruction.
  - Undefined: every instruction passes through M for at least one cycle.
  - Retire counting and the watchdog are identical in both builds.

## Test plan
- Reset, then imem_ack=1 and dmem_ack=1 tied high, mem_op=1:
  - phase sequence is 01,02,04,08,10,01.
  - retire_cnt=1 after cycle 5, and 4 after 20 cycles.
- imem_ack held low 3 cycles, then high:
  - F lasts 4 cycles with imem_req=1 throughout.
  - R follows.
  - wait_cnt clears on entry to R.
- mem_op=1, dmem_ack first high in the 6th M cycle: M lasts 6 cycles and dmem_req=1 throughout. With mem_op=0:
  - Macro undefined: M lasts 1 cycle.
  - PHASE_SKIP_M_EN defined: X is followed directly by W (phase 04 to 10).
- halt=1 in W:
  - phase=00, halted=1, imem_req=0.
  - resume=1 gives phase=01 on the next cycle.
  - retire_cnt includes the halt instruction.
- WAIT_W=3, imem_ack never asserted:
  - after 7 wait cycles, bus_err=1 and halted=1.
  - resume is ignored.
  - rst then gives phase=01, bus_err=0.
  - Repeat with ack arriving on the 7th wait cycle: expect R and bus_err=0.
